// File: rtl/ordenator_pkg.sv
// Shared definitions for the ordenator sorter and its serial output streamer.
package ordenator_pkg;

  // Frame geometry shared by the sorter and the streamer.
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DATA_SIZE  = 9;

  // Streamer control states.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } stream_state_e;

endpackage

// File: rtl/ordered_streamer.sv
// Captures a sorted parallel frame and streams it element by element on a
// valid/ready interface, flagging any descending step seen while streaming.
//
// Handshake: a beat transfers on a rising edge where valid_o && ready_i.
// Once valid_o is high, data_o/idx_o/last_o hold until that transfer and
// valid_o never falls without one; ready_i may change on any cycle.
module ordered_streamer
  import ordenator_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DATA_SIZE  = DEFAULT_DATA_SIZE,
  localparam int IDX_W     = $clog2(DATA_SIZE)
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic [DATA_SIZE-1:0][DATA_WIDTH-1:0] numbers_i,
  input  logic                                 load_i,
  output logic                                 busy_o,
  output logic [DATA_WIDTH-1:0]                data_o,
  output logic [IDX_W-1:0]                     idx_o,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic                                 last_o,
  output logic                                 done_o,
  output logic                                 order_err_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_SIZE - 1);

  stream_state_e                        state_q;
  stream_state_e                        state_d;
  logic [DATA_SIZE-1:0][DATA_WIDTH-1:0] buf_q;
  logic [IDX_W-1:0]                     idx_q;
  logic [DATA_WIDTH-1:0]                prev_q;
  logic                                 err_q;
  logic                                 done_q;

  logic                                 capture;
  logic                                 accept;
  logic                                 at_last;
  logic [DATA_WIDTH-1:0]                cur_data;

  // Loads are honoured only in IDLE; a load during SEND is dropped.
  assign capture  = (state_q == IDLE) && load_i;
  assign accept   = (state_q == SEND) && ready_i;
  assign at_last  = (idx_q == LAST_IDX);
  assign cur_data = buf_q[idx_q];

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: leave IDLE on a capture, return after the last beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_i) state_d = SEND;
      SEND:    if (ready_i && at_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; beat fields read as zero outside SEND.
  always_comb begin
    valid_o     = 1'b0;
    busy_o      = 1'b0;
    data_o      = '0;
    idx_o       = '0;
    last_o      = 1'b0;
    done_o      = done_q;
    order_err_o = err_q;
    if (state_q == SEND) begin
      valid_o = 1'b1;
      busy_o  = 1'b1;
      data_o  = cur_data;
      idx_o   = idx_q;
      last_o  = at_last;
    end
  end

  // Frame buffer: written only on a capture, so a frame in flight is safe.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)      buf_q <= '0;
    else if (capture) buf_q <= numbers_i;
  end

  // Beat index: restarts on capture, advances on each accepted beat and
  // wraps to zero after the final one so it never passes DATA_SIZE-1.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)      idx_q <= '0;
    else if (capture) idx_q <= '0;
    else if (accept)  idx_q <= at_last ? '0 : idx_q + 1'b1;
  end

  // Order checker: compares each accepted beat after the first against the
  // previously accepted one; the flag sticks until the next capture.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else if (capture) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      prev_q <= cur_data;
      if ((idx_q != '0) && (cur_data < prev_q)) err_q <= 1'b1;
    end
  end

  // Completion pulse in the cycle after the final beat is accepted.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) done_q <= 1'b0;
    else         done_q <= accept && at_last;
  end

endmodule

// File: tb/tb_ordered_streamer.sv
// Directed bench for ordered_streamer: a per-cycle vector table plus
// hand-written sequences for backpressure and mid-frame reset.
module tb_ordered_streamer;

  localparam int DW    = 8;
  localparam int DS    = 9;
  localparam int IW    = 4;
  localparam int F_UP1 = 0;  // 1..9
  localparam int F_ERR = 1;  // 1,2,5,3,6,7,8,9,9
  localparam int F_NIN = 2;  // all 9
  localparam int F_UP0 = 3;  // 0..8

  typedef struct {
    logic          load;
    logic          ready;
    int            frame;
    logic          valid;
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
    logic          done;
    logic          err;
  } vec_t;

  logic                         clk_i;
  logic                         rstn_i;
  logic [DS-1:0][DW-1:0]        numbers_i;
  logic                         load_i;
  logic                         busy_o;
  logic [DW-1:0]                data_o;
  logic [IW-1:0]                idx_o;
  logic                         valid_o;
  logic                         ready_i;
  logic                         last_o;
  logic                         done_o;
  logic                         order_err_o;

  logic [DS-1:0][DW-1:0]        frames [4];
  vec_t                         vec_q[$];
  logic [DW-1:0]                exp_q[$];
  int                           n_tests;
  int                           n_fail;

  ordered_streamer #(.DATA_WIDTH(DW), .DATA_SIZE(DS)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .numbers_i   (numbers_i),
    .load_i      (load_i),
    .busy_o      (busy_o),
    .data_o      (data_o),
    .idx_o       (idx_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .last_o      (last_o),
    .done_o      (done_o),
    .order_err_o (order_err_o)
  );

  // Clock and reset.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic ld, input logic rd, input int fr, input logic v,
                     input int d, input int i, input logic l, input logic dn, input logic e);
    vec_t r;
    r.load = ld; r.ready = rd; r.frame = fr; r.valid = v;
    r.data = DW'(d); r.idx = IW'(i); r.last = l; r.done = dn; r.err = e;
    vec_q.push_back(r);
  endtask

  task automatic check_outputs(input string tag, input logic v, input int d, input int i,
                               input logic l, input logic dn, input logic e);
    check({tag, " valid"}, 32'(valid_o), 32'(v));
    check({tag, " busy"},  32'(busy_o),  32'(v));
    check({tag, " data"},  32'(data_o),  32'(d));
    check({tag, " idx"},   32'(idx_o),   32'(i));
    check({tag, " last"},  32'(last_o),  32'(l));
    check({tag, " done"},  32'(done_o),  32'(dn));
    check({tag, " err"},   32'(order_err_o), 32'(e));
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [DW-1:0] err_vals [DS];
    logic          pat [4];
    logic          pv;
    logic [DW-1:0] pd;
    logic [IW-1:0] pi;
    logic          seen_done;
    int            exp_idx;

    n_tests = 0;
    n_fail  = 0;
    err_vals = '{8'd1, 8'd2, 8'd5, 8'd3, 8'd6, 8'd7, 8'd8, 8'd9, 8'd9};
    pat      = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < DS; i++) begin
      frames[F_UP1][i] = DW'(i + 1);
      frames[F_ERR][i] = err_vals[i];
      frames[F_NIN][i] = DW'(9);
      frames[F_UP0][i] = DW'(i);
    end

    // Vector table, one record per clock edge; expectations are post-edge.
    // Frame A: 1..9 at full throughput.
    add(1, 1, F_UP1, 1, 1, 0, 0, 0, 0);
    for (int k = 1; k < DS; k++) add(0, 1, F_UP1, 1, k + 1, k, k == DS - 1, 0, 0);
    add(0, 1, F_UP1, 0, 0, 0, 0, 1, 0);
    add(0, 1, F_UP1, 0, 0, 0, 0, 0, 0);
    // Frame B: 3 follows 5 at idx 3; the flag shows after that beat's accept.
    add(1, 1, F_ERR, 1, 1, 0, 0, 0, 0);
    for (int k = 1; k < DS; k++) add(0, 1, F_ERR, 1, err_vals[k], k, k == DS - 1, 0, k >= 4);
    add(0, 1, F_ERR, 0, 0, 0, 0, 1, 1);
    add(0, 1, F_ERR, 0, 0, 0, 0, 0, 1);
    // Frame C: the next capture clears the flag; a load at beat 4 is ignored.
    add(1, 1, F_UP1, 1, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) add(0, 1, F_UP1, 1, k + 1, k, 0, 0, 0);
    add(1, 1, F_NIN, 1, 6, 5, 0, 0, 0);
    for (int k = 6; k < DS; k++) add(0, 1, F_UP1, 1, k + 1, k, k == DS - 1, 0, 0);
    add(0, 1, F_UP1, 0, 0, 0, 0, 1, 0);
    // Frame D: load in the done cycle starts the next frame one cycle later.
    add(1, 1, F_UP0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k < DS; k++) add(0, 1, F_UP0, 1, k, k, k == DS - 1, 0, 0);
    add(0, 1, F_UP0, 0, 0, 0, 0, 1, 0);
    add(0, 1, F_UP0, 0, 0, 0, 0, 0, 0);

    // Reset.
    rstn_i    = 1'b0;
    load_i    = 1'b0;
    ready_i   = 1'b0;
    numbers_i = frames[F_UP1];
    repeat (2) @(posedge clk_i);
    #1;
    check_outputs("reset", 0, 0, 0, 0, 0, 0);
    rstn_i = 1'b1;
    step();
    check_outputs("post_reset_idle", 0, 0, 0, 0, 0, 0);

    // Table run.
    for (int i = 0; i < vec_q.size(); i++) begin
      load_i    = vec_q[i].load;
      ready_i   = vec_q[i].ready;
      numbers_i = frames[vec_q[i].frame];
      step();
      check_outputs($sformatf("vec%0d", i), vec_q[i].valid, vec_q[i].data, vec_q[i].idx,
                    vec_q[i].last, vec_q[i].done, vec_q[i].err);
    end

    // Backpressure: ready pattern 1,0,0,1; beats must freeze while stalled
    // and arrive exactly once each, in order.
    for (int k = 1; k <= DS; k++) exp_q.push_back(DW'(k));
    load_i    = 1'b1;
    ready_i   = 1'b0;
    numbers_i = frames[F_UP1];
    step();
    load_i    = 1'b0;
    seen_done = 1'b0;
    exp_idx   = 0;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      ready_i = pat[c % 4];
      pv = valid_o;
      pd = data_o;
      pi = idx_o;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check("bp_extra_beat", 32'(data_o), 32'hFFFF_FFFF);
        end else begin
          check("bp_data", 32'(data_o), 32'(exp_q.pop_front()));
          check("bp_idx",  32'(idx_o),  32'(exp_idx));
          check("bp_last", 32'(last_o), 32'(exp_idx == DS - 1));
          exp_idx++;
        end
      end
      step();
      if (pv && !ready_i) begin
        check("bp_hold_valid", 32'(valid_o), 32'd1);
        check("bp_hold_data",  32'(data_o),  32'(pd));
        check("bp_hold_idx",   32'(idx_o),   32'(pi));
      end
      if (done_o) seen_done = 1'b1;
    end
    check("bp_done_seen", 32'(seen_done), 32'd1);
    check("bp_all_beats", 32'(exp_q.size()), 32'd0);
    check("bp_err", 32'(order_err_o), 32'd0);
    ready_i = 1'b0;
    step();

    // Reset mid-frame at beat 5.
    load_i    = 1'b1;
    ready_i   = 1'b1;
    numbers_i = frames[F_UP1];
    step();
    load_i = 1'b0;
    repeat (5) step();
    check_outputs("pre_reset_beat5", 1, 6, 5, 0, 0, 0);
    #2;
    rstn_i = 1'b0;
    #1;
    check_outputs("async_reset", 0, 0, 0, 0, 0, 0);
    step();
    rstn_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check_outputs($sformatf("after_reset%0d", k), 0, 0, 0, 0, 0, 0);
    end
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    check_outputs("reload_after_reset", 1, 1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
